// File: rtl/run_ctrl.sv
// Run controller: registered CPU clock-enable with free-run, single-step and halt-drain.
// Optional enabled-cycle watchdog is compiled in with `define RUN_CTRL_WATCHDOG_EN.
module run_ctrl #(
    parameter int CNT_W      = 32,
    parameter int HALT_DRAIN = 4,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             CLOCK,
    input  logic             nRESET,
    input  logic             START,
    input  logic             STEP,
    input  logic             STOP,
    input  logic             HALT,
    output logic             CPU_EN,
    output logic [CNT_W-1:0] CYCLES,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [3:0]       DRAIN_LOAD = 4'(HALT_DRAIN);
    localparam logic [CNT_W-1:0] CYC_MAX    = '1;

    if (HALT_DRAIN < 0 || HALT_DRAIN > 15 || MAX_CYCLES < 1) begin : gBadParams
        $error("run_ctrl: HALT_DRAIN must be 0..15 and MAX_CYCLES at least 1");
    end

    state_t           state_q, state_d;
    logic [3:0]       drainCnt_q, drainCnt_d;
    logic             startPrev_q, stepPrev_q;
    logic             cpuEn_q, done_q, timeout_q;
    logic [CNT_W-1:0] cycles_q;
    logic             startEdge, stepEdge, wdFire, setTimeout, clearCnt;

    assign startEdge = START & ~startPrev_q;
    assign stepEdge  = STEP & ~stepPrev_q;

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
    // RUN always has the enable high, so only the count needs comparing.
    assign wdFire = (cycles_q == WD_LAST);
`else
    assign wdFire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        setTimeout = 1'b0;
        clearCnt   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (startEdge) begin
                    state_d = ST_RUN;
                end else if (stepEdge) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if (HALT) begin
                    if (DRAIN_LOAD == 4'd0) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d    = ST_DRAIN;
                        drainCnt_d = DRAIN_LOAD;
                    end
                end else if (state_q == ST_RUN && wdFire) begin
                    state_d    = ST_HALTED;
                    setTimeout = 1'b1;
                end else if (state_q == ST_STEP || STOP) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                drainCnt_d = drainCnt_q - 4'd1;
                if (drainCnt_q <= 4'd1) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (startEdge) begin
                    state_d  = ST_IDLE;
                    clearCnt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so CPU_EN never glitches.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= ST_IDLE;
            drainCnt_q  <= 4'd0;
            startPrev_q <= 1'b0;
            stepPrev_q  <= 1'b0;
            cpuEn_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            drainCnt_q  <= drainCnt_d;
            startPrev_q <= START;
            stepPrev_q  <= STEP;
            cpuEn_q     <= (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
            done_q      <= (state_d == ST_HALTED);
            if (clearCnt) begin
                cycles_q  <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (cpuEn_q && cycles_q != CYC_MAX) begin
                    cycles_q <= cycles_q + 1'b1;
                end
                if (setTimeout) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign CPU_EN  = cpuEn_q;
    assign BUSY    = cpuEn_q;
    assign DONE    = done_q;
    assign TIMEOUT = timeout_q;
    assign CYCLES  = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: a behavioural model predicts every cycle's outputs.
// The model follows RUN_CTRL_WATCHDOG_EN the same way the design does.
module tb_run_ctrl;

    localparam int CNT_W      = 8;
    localparam int HALT_DRAIN = 4;
    localparam int MAX_CYCLES = 20;
    localparam int CYC_SAT    = (1 << CNT_W) - 1;

    logic             CLOCK = 1'b0;
    logic             nRESET = 1'b1;
    logic             START = 1'b0;
    logic             STEP = 1'b0;
    logic             STOP = 1'b0;
    logic             HALT = 1'b0;
    logic             CPU_EN;
    logic [CNT_W-1:0] CYCLES;
    logic             BUSY;
    logic             DONE;
    logic             TIMEOUT;

    run_ctrl #(
        .CNT_W     (CNT_W),
        .HALT_DRAIN(HALT_DRAIN),
        .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .CLOCK  (CLOCK),
        .nRESET (nRESET),
        .START  (START),
        .STEP   (STEP),
        .STOP   (STOP),
        .HALT   (HALT),
        .CPU_EN (CPU_EN),
        .CYCLES (CYCLES),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .TIMEOUT(TIMEOUT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic             en;
        logic             busy;
        logic             done;
        logic             timeout;
        logic [CNT_W-1:0] cycles;
    } resp_t;

    resp_t expQ[$];
    int    testsRun    = 0;
    int    testsFailed = 0;

    // Model: which activity is going on, how many enabled drain cycles remain, totals.
    bit mRunning, mStepping, mHalted, mTimeout, mStartPrev, mStepPrev;
    int mDrainLeft, mCycles;

    function automatic bit modelEnabled();
        return mRunning || mStepping || (mDrainLeft > 0);
    endfunction

    task automatic modelReset();
        mRunning   = 0;
        mStepping  = 0;
        mHalted    = 0;
        mTimeout   = 0;
        mStartPrev = 0;
        mStepPrev  = 0;
        mDrainLeft = 0;
        mCycles    = 0;
    endtask

    task automatic modelStep(input bit s, input bit t, input bit p, input bit h);
        bit enBefore, sEdge, tEdge, wdFire;
        int newCycles;
        enBefore  = modelEnabled();
        sEdge     = s && !mStartPrev;
        tEdge     = t && !mStepPrev;
        wdFire    = 0;
`ifdef RUN_CTRL_WATCHDOG_EN
        wdFire    = mRunning && (mCycles + 1 == MAX_CYCLES);
`endif
        newCycles = (enBefore && mCycles < CYC_SAT) ? mCycles + 1 : mCycles;
        if (mHalted) begin
            if (sEdge) begin
                mHalted   = 0;
                newCycles = 0;
                mTimeout  = 0;
            end
        end else if (mDrainLeft > 0) begin
            mDrainLeft--;
            if (mDrainLeft == 0) mHalted = 1;
        end else if (mRunning || mStepping) begin
            if (h) begin
                mRunning   = 0;
                mStepping  = 0;
                mDrainLeft = HALT_DRAIN;
                if (HALT_DRAIN == 0) mHalted = 1;
            end else if (wdFire) begin
                mRunning = 0;
                mHalted  = 1;
                mTimeout = 1;
            end else if (mStepping || p) begin
                mRunning  = 0;
                mStepping = 0;
            end
        end else begin
            if (sEdge) mRunning = 1;
            else if (tEdge) mStepping = 1;
        end
        mCycles    = newCycles;
        mStartPrev = s;
        mStepPrev  = t;
    endtask

    task automatic pushExpected();
        resp_t r;
        r.en      = modelEnabled();
        r.busy    = modelEnabled();
        r.done    = mHalted;
        r.timeout = mTimeout;
        r.cycles  = CNT_W'(mCycles);
        expQ.push_back(r);
    endtask

    // Called half a cycle before a rising edge; returns just after the next falling edge.
    task automatic applyStimulus(input bit s, input bit t, input bit p, input bit h);
        START = s;
        STEP  = t;
        STOP  = p;
        HALT  = h;
        if (!nRESET) modelReset();
        else modelStep(s, t, p, h);
        pushExpected();
        @(negedge CLOCK);
        #1;
    endtask

    // Asserts reset in the middle of a clock-high phase to show it acts without an edge.
    task automatic resetPulse();
        START = 0;
        STEP  = 0;
        STOP  = 0;
        HALT  = 0;
        @(posedge CLOCK);
        #2;
        nRESET = 0;
        modelReset();
        pushExpected();
        @(negedge CLOCK);
        #1;
        applyStimulus(0, 0, 0, 0);
        nRESET = 1;
    endtask

    task automatic checkOutput(input resp_t e);
        resp_t a;
        a.en      = CPU_EN;
        a.busy    = BUSY;
        a.done    = DONE;
        a.timeout = TIMEOUT;
        a.cycles  = CYCLES;
        testsRun++;
        if (a !== e) begin
            testsFailed++;
            $display("[TB] FAIL cycle-compare t=%0t: got en=%b busy=%b done=%b to=%b cyc=%0d, expected en=%b busy=%b done=%b to=%b cyc=%0d",
                     $time, a.en, a.busy, a.done, a.timeout, a.cycles,
                     e.en, e.busy, e.done, e.timeout, e.cycles);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: consumes one prediction per falling edge, independent of the driver.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        bit sLvl, tLvl;
        modelReset();
        #2 nRESET = 0;
        @(negedge CLOCK);
        #1;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        nRESET = 1;
        checkValue("reset cpu_en", int'(CPU_EN), 0);
        checkValue("reset cycles", int'(CYCLES), 0);

        // Run, HALT ten cycles after START, drain of four.
        applyStimulus(1, 0, 0, 0);
        checkValue("start latency", int'(CPU_EN), 1);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
        checkValue("halt cycles", int'(CYCLES), 14);
        checkValue("halt done", int'(DONE), 1);
        checkValue("halt busy", int'(BUSY), 0);
        applyStimulus(1, 0, 0, 0);
        checkValue("restart cycles", int'(CYCLES), 0);
        checkValue("restart done", int'(DONE), 0);
        applyStimulus(0, 0, 0, 0);

        // Three single steps.
        resetPulse();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkValue("step pulse", int'(CPU_EN), 1);
            applyStimulus(0, 0, 0, 0);
            checkValue("step end", int'(BUSY), 0);
            applyStimulus(0, 0, 0, 0);
        end
        checkValue("step cycles", int'(CYCLES), 3);

        // START and STEP together, STOP five cycles later.
        resetPulse();
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkValue("stop cpu_en", int'(CPU_EN), 0);
        checkValue("stop cycles", int'(CYCLES), 5);
        checkValue("stop done", int'(DONE), 0);
        applyStimulus(0, 0, 0, 0);

        // Long free run: watchdog or counter saturation.
        resetPulse();
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 50; i++) applyStimulus(0, 0, 0, 0);
`ifdef RUN_CTRL_WATCHDOG_EN
        checkValue("wd cycles", int'(CYCLES), MAX_CYCLES);
        checkValue("wd timeout", int'(TIMEOUT), 1);
        checkValue("wd done", int'(DONE), 1);
        checkValue("wd cpu_en", int'(CPU_EN), 0);
        applyStimulus(1, 0, 0, 0);
        checkValue("wd clear cycles", int'(CYCLES), 0);
        checkValue("wd clear timeout", int'(TIMEOUT), 0);
        checkValue("wd clear done", int'(DONE), 0);
`else
        checkValue("free cpu_en", int'(CPU_EN), 1);
        checkValue("free timeout", int'(TIMEOUT), 0);
        checkValue("free cycles", int'(CYCLES), 50);
        for (int i = 0; i < 210; i++) applyStimulus(0, 0, 0, 0);
        checkValue("saturate", int'(CYCLES), CYC_SAT);
        applyStimulus(0, 0, 1, 0);
        checkValue("saturate after stop", int'(CYCLES), CYC_SAT);
`endif
        applyStimulus(0, 0, 0, 0);

        // Reset in the middle of a drain.
        resetPulse();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkValue("mid drain busy", int'(BUSY), 1);
        resetPulse();
        checkValue("drain reset cpu_en", int'(CPU_EN), 0);
        checkValue("drain reset cycles", int'(CYCLES), 0);
        checkValue("drain reset done", int'(DONE), 0);
        applyStimulus(1, 0, 0, 0);
        checkValue("post reset start", int'(CPU_EN), 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        checkValue("post reset cycles", int'(CYCLES), 3);

        // Random traffic with occasional asynchronous resets.
        sLvl = 0;
        tLvl = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 2) begin
                resetPulse();
                sLvl = 0;
                tLvl = 0;
            end else begin
                if ($urandom_range(99) < 12) sLvl = ~sLvl;
                if ($urandom_range(99) < 15) tLvl = ~tLvl;
                applyStimulus(sLvl, tLvl, $urandom_range(99) < 6, $urandom_range(99) < 5);
            end
        end

        @(negedge CLOCK);
        #1;
        checkValue("queue drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
